// File: rtl/imem_loader.sv
// Byte-stream loader: assembles little-endian 32-bit words and writes them sequentially into
// instruction memory. Optional running checksum is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_left;
  logic [1:0]          r_idx;
  logic [23:0]         r_asm;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_error;
  logic                r_zero_done;

  logic                w_idle_start;
  logic                w_xfer;
  logic [ADDR_W+1:0]   w_end;
  logic                w_range_bad;
  logic                w_start_ok;

  assign w_idle_start = start && (r_state == StIdle);
  assign w_xfer       = (r_state == StLoad) && byte_valid;
  assign w_end        = {2'b00, base_addr} + {1'b0, word_count};
  assign w_range_bad  = w_end > (ADDR_W+2)'(DEPTH);
  assign w_start_ok   = w_idle_start && (word_count != '0) && !w_range_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_next = StLoad;
      StLoad:  if (w_xfer && (r_idx == 2'd3)) w_state_next = StWrite;
      StWrite: w_state_next = (r_left == (ADDR_W+1)'(1)) ? StDone : StLoad;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    byte_ready = (r_state == StLoad);
    mem_we     = (r_state == StWrite);
    busy       = (r_state == StLoad) || (r_state == StWrite);
    done       = (r_state == StDone) || r_zero_done;
    mem_addr   = r_mem_addr;
    mem_wdata  = r_mem_wdata;
    error      = r_error;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_left      <= '0;
      r_idx       <= '0;
      r_asm       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_error     <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      if (w_idle_start) begin
        if (word_count == '0) begin
          r_zero_done <= 1'b1;
          r_error     <= 1'b0;
        end else if (w_range_bad) begin
          r_error <= 1'b1;
        end else begin
          r_addr  <= base_addr;
          r_left  <= word_count;
          r_idx   <= '0;
          r_asm   <= '0;
          r_error <= 1'b0;
        end
      end
      if (w_xfer) begin
        r_idx <= r_idx + 2'd1;
        unique case (r_idx)
          2'd0: r_asm[7:0]   <= byte_data;
          2'd1: r_asm[15:8]  <= byte_data;
          2'd2: r_asm[23:16] <= byte_data;
          2'd3: begin
            // Capture the full word now so mem_addr/mem_wdata hold after the write cycle.
            r_mem_wdata <= {byte_data, r_asm};
            r_mem_addr  <= r_addr;
          end
          default: ;
        endcase
      end
      if (r_state == StWrite) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_left <= r_left - (ADDR_W+1)'(1);
        r_idx  <= '0;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_checksum <= '0;
    else if (w_start_ok)           r_checksum <= '0;
    else if (r_state == StWrite)   r_checksum <= r_checksum + r_mem_wdata;
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by stimulus, a negedge monitor
// pops and compares on every mem_we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  int total = 0;
  int bad   = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  bq[$];
  time         t_first;
  time         t_done;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .DEPTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {24'h0, mem_addr}, {24'h0, e[39:32]});
        check("write_data", mem_wdata, e[31:0]);
        check("ready_in_write", {31'h0, byte_ready}, 32'h0);
      end
    end
  end

  task automatic do_start(input logic [7:0] base, input logic [8:0] cnt);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents bq one byte at a time; with gaps, valid follows 1,0,0,1,0,0,...
  task automatic send_bytes(input bit gaps);
    int i = 0;
    int cyc = 0;
    while (i < bq.size() && cyc < 400) begin
      @(negedge clk);
      byte_valid = gaps ? ((cyc % 3) == 0) : 1'b1;
      byte_data  = bq[i];
      if (byte_valid && byte_ready) begin
        if (i == 0) t_first = $time;
        i++;
      end
      cyc++;
    end
    if (i < bq.size()) begin
      total++;
      bad++;
      $display("FAIL send_timeout: sent %0d of %0d bytes", i, bq.size());
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (done) begin
        got    = 1'b1;
        t_done = $time;
      end else begin
        @(negedge clk);
      end
    end
    check("done_seen", {31'h0, got}, 32'h1);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (2) @(negedge clk);
    check("reset_flags", {27'h0, byte_ready, mem_we, busy, done, error}, 32'h0);
    check("reset_addr", {24'h0, mem_addr}, 32'h0);
    check("reset_wdata", mem_wdata, 32'h0);
    check("reset_checksum", checksum, 32'h0);
    rst = 1'b0;

    // Basic load, valid held high
    exp_q.push_back({8'd0, 32'h02710337});
    exp_q.push_back({8'd1, 32'h00008397});
    do_start(8'd0, 9'd2);
    check("busy_after_start", {31'h0, busy}, 32'h1);
    bq = {8'h37, 8'h03, 8'h71, 8'h02, 8'h97, 8'h83, 8'h00, 8'h00};
    send_bytes(1'b0);
    wait_done();
    check("elapsed_cycles", 32'((t_done - t_first) / 10), 32'd10);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("basic_checksum", checksum, 32'h027186CE);
`else
    check("basic_checksum", checksum, 32'h0);
`endif
    @(negedge clk);
    check("busy_after_done", {30'h0, busy, done}, 32'h0);

    // Same load with backpressure gaps
    exp_q.push_back({8'd0, 32'h02710337});
    exp_q.push_back({8'd1, 32'h00008397});
    do_start(8'd0, 9'd2);
    send_bytes(1'b1);
    wait_done();
    check("gaps_queue_empty", 32'(exp_q.size()), 32'd0);

    // Range reject, then a legal load that just fits
    do_start(8'd60, 9'd5);
    check("reject_error", {31'h0, error}, 32'h1);
    @(negedge clk);
    check("reject_busy", {30'h0, busy, byte_ready}, 32'h0);
    exp_q.push_back({8'd60, 32'h13121110});
    exp_q.push_back({8'd61, 32'h17161514});
    exp_q.push_back({8'd62, 32'h1B1A1918});
    exp_q.push_back({8'd63, 32'h1F1E1D1C});
    do_start(8'd60, 9'd4);
    check("accept_clears_error", {31'h0, error}, 32'h0);
    bq.delete();
    for (int k = 0; k < 16; k++) bq.push_back(8'(8'h10 + k));
    send_bytes(1'b0);
    wait_done();
    check("range_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero count: done pulse on the next cycle only
    do_start(8'd3, 9'd0);
    check("zero_done", {29'h0, done, byte_ready, busy}, 32'h4);
    @(negedge clk);
    check("zero_done_pulse", {30'h0, done, byte_ready}, 32'h0);

    // Reset after 2 of 4 bytes
    do_start(8'd7, 9'd1);
    bq = {8'hAA, 8'hBB};
    send_bytes(1'b0);
    rst = 1'b1;
    #1;
    check("midrst_flags", {27'h0, byte_ready, mem_we, busy, done, error}, 32'h0);
    check("midrst_addr", {24'h0, mem_addr}, 32'h0);
    check("midrst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({8'd5, 32'h00a00013});
    do_start(8'd5, 9'd1);
    bq = {8'h13, 8'h00, 8'hA0, 8'h00};
    send_bytes(1'b0);
    wait_done();

    // Checksum wraps to zero: 1 + FFFFFFFF
    exp_q.push_back({8'd10, 32'h00000001});
    exp_q.push_back({8'd11, 32'hFFFFFFFF});
    do_start(8'd10, 9'd2);
    bq = {8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_bytes(1'b0);
    wait_done();
    check("wrap_checksum", checksum, 32'h0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
